// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared definitions for the sequential wide comparator: nibble width and
// controller state encoding.
package cmp_seq_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_4b.sv
// Combinational 4-bit magnitude comparator, the shared datapath of the sequencer.
module cmp_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequencer that walks a wide operand pair MSB-nibble first through one cmp_4b,
// producing registered gt/eq/lt, a done pulse and the number of nibbles examined.
module cmp_seq_ctrl
    import cmp_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES    = 4,
    parameter int EARLY_EXIT = 1,
    localparam int W  = NIB_W * NIBBLES,
    localparam int CW = $clog2(NIBBLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic          busy,
    output logic          done,
    output logic          gt,
    output logic          eq,
    output logic          lt,
    output logic [CW-1:0] cycles
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IW-1:0]   idx_reg;
    logic            decided_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            gt_reg;
    logic            eq_reg;
    logic            lt_reg;
    logic [CW-1:0]   cycles_reg;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic             nib_gt;
    logic             nib_eq;
    logic             nib_lt;
    logic             nib_diff;

    assign a_nib    = a_reg[idx_reg*NIB_W +: NIB_W];
    assign b_nib    = b_reg[idx_reg*NIB_W +: NIB_W];
    assign nib_diff = nib_gt | nib_lt;

    cmp_4b u_cmp (
        .a  (a_nib),
        .b  (b_nib),
        .gt (nib_gt),
        .eq (nib_eq),
        .lt (nib_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            idx_reg     <= '0;
            decided_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            gt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
            lt_reg      <= 1'b0;
            cycles_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg       <= A;
                        b_reg       <= B;
                        idx_reg     <= IDX_TOP;
                        decided_reg <= 1'b0;
                        gt_reg      <= 1'b0;
                        eq_reg      <= 1'b0;
                        lt_reg      <= 1'b0;
                        cycles_reg  <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycles_reg <= cycles_reg + CW'(1);
                    // Only the most significant differing nibble decides the result.
                    if (!decided_reg && nib_diff) begin
                        decided_reg <= 1'b1;
                        gt_reg      <= nib_gt;
                        lt_reg      <= nib_lt;
                    end
                    if ((EARLY_EXIT != 0) && nib_diff) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (idx_reg == '0) begin
                        if (!decided_reg && nib_eq)
                            eq_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg - IW'(1);
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign gt     = gt_reg;
    assign eq     = eq_reg;
    assign lt     = lt_reg;
    assign cycles = cycles_reg;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: early-exit, constant-time and single-nibble instances
// share one stimulus stream and are checked for result, cycle count and timing.
module tb_cmp_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic        busy_v [3];
    logic        done_v [3];
    logic        gt_v   [3];
    logic        eq_v   [3];
    logic        lt_v   [3];
    logic [2:0]  cyc_e;
    logic [2:0]  cyc_c;
    logic [0:0]  cyc_1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_seq_ctrl #(.NIBBLES(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]),
        .lt(lt_v[0]), .cycles(cyc_e)
    );

    cmp_seq_ctrl #(.NIBBLES(4), .EARLY_EXIT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]),
        .lt(lt_v[1]), .cycles(cyc_c)
    );

    cmp_seq_ctrl #(.NIBBLES(1), .EARLY_EXIT(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in[3:0]), .B(b_in[3:0]),
        .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]),
        .lt(lt_v[2]), .cycles(cyc_1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          r;      // 0 = equal, 1 = A>B, 2 = A<B
        int          k_ee;   // nibbles examined with early exit
        int          k_ct;   // nibbles examined in constant-time mode
    } vec_t;

    vec_t tbl [7];

    function automatic int get_cyc(input int d);
        case (d)
            0:       return int'(cyc_e);
            1:       return int'(cyc_c);
            default: return int'(cyc_1);
        endcase
    endfunction

    function automatic int flags_of(input int d);
        return {29'd0, gt_v[d], eq_v[d], lt_v[d]};
    endfunction

    function automatic int flags_exp(input int r);
        case (r)
            0:       return 3'b010;
            1:       return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Reference: ordering by plain integer comparison; with early exit the number
    // of nibbles examined is how far down the most significant differing bit sits.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input int n, input bit ee,
                                  output int r, output int k);
        logic [15:0] diff;
        int h;
        r = (a > b) ? 1 : (a < b) ? 2 : 0;
        diff = a ^ b;
        h = -1;
        for (int i = 0; i < 16; i++)
            if (diff[i]) h = i;
        k = (!ee || h < 0) ? n : n - h / 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_busy%0d", tag, d), int'(busy_v[d]), 0);
            chk($sformatf("%s_done%0d", tag, d), int'(done_v[d]), 0);
            chk($sformatf("%s_flags%0d", tag, d), flags_of(d), 0);
            chk($sformatf("%s_cycles%0d", tag, d), get_cyc(d), 0);
        end
    endtask

    // One start pulse; watch 20 cycles so late or duplicate done pulses are caught.
    task automatic run_compare(input logic [15:0] a, input logic [15:0] b,
                               input int exp_r [3], input int exp_k [3]);
        int done_at [3];
        int done_cnt [3];
        int busy_cnt [3];
        for (int d = 0; d < 3; d++) begin
            done_at[d] = -1; done_cnt[d] = 0; busy_cnt[d] = 0;
        end
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom);
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (busy_v[d]) busy_cnt[d]++;
                if (done_v[d]) begin
                    done_cnt[d]++;
                    if (done_at[d] < 0) done_at[d] = j;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("flags%0d", d), flags_of(d), flags_exp(exp_r[d]));
            chk($sformatf("cycles%0d", d), get_cyc(d), exp_k[d]);
            chk($sformatf("done_at%0d", d), done_at[d], exp_k[d]);
            chk($sformatf("done_cnt%0d", d), done_cnt[d], 1);
            chk($sformatf("busy_cnt%0d", d), busy_cnt[d], exp_k[d]);
        end
        $display("txn a=%h b=%h ee:r=%0d k=%0d ct:r=%0d k=%0d n1:r=%0d k=%0d",
                 a, b, exp_r[0], exp_k[0], exp_r[1], exp_k[1], exp_r[2], exp_k[2]);
    endtask

    task automatic run_model(input logic [15:0] a, input logic [15:0] b);
        int er [3];
        int ek [3];
        model(a, b, 4, 1'b1, er[0], ek[0]);
        model(a, b, 4, 1'b0, er[1], ek[1]);
        model({12'd0, a[3:0]}, {12'd0, b[3:0]}, 1, 1'b1, er[2], ek[2]);
        run_compare(a, b, er, ek);
    endtask

    initial begin
        int er [3];
        int ek [3];
        int since_done;
        int n_done;

        tbl[0] = '{16'h1234, 16'h1234, 0, 4, 4};
        tbl[1] = '{16'h8000, 16'h7FFF, 1, 1, 4};
        tbl[2] = '{16'h1234, 16'h1235, 2, 4, 4};
        tbl[3] = '{16'h9000, 16'h1FFF, 1, 1, 4};
        tbl[4] = '{16'h00F0, 16'h0F00, 2, 2, 4};
        tbl[5] = '{16'h0001, 16'h0002, 2, 4, 4};
        tbl[6] = '{16'hFFFF, 16'h0000, 1, 1, 4};

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors; the single-nibble instance uses the model.
        for (int t = 0; t < 7; t++) begin
            er[0] = tbl[t].r;  ek[0] = tbl[t].k_ee;
            er[1] = tbl[t].r;  ek[1] = tbl[t].k_ct;
            model({12'd0, tbl[t].a[3:0]}, {12'd0, tbl[t].b[3:0]}, 1, 1'b1, er[2], ek[2]);
            run_compare(tbl[t].a, tbl[t].b, er, ek);
        end

        // Reset during the second RUN cycle aborts with no done.
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h1234; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", int'(done_v[0] | done_v[1] | done_v[2]), 0);
        end
        $display("txn reset-abort a=1234 b=1234");
        er = '{2, 2, 2};
        ek = '{4, 4, 1};
        run_compare(16'h0001, 16'h0002, er, ek);

        // start held high: back-to-back compares, one IDLE cycle after each done.
        @(negedge clk);
        a_in = 16'h00F0; b_in = 16'h0F00; start = 1'b1;
        @(posedge clk);
        since_done = -1;
        n_done = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done_v[0]) begin
                n_done++;
                chk("hs_flags", flags_of(0), 3'b001);
                chk("hs_cycles", get_cyc(0), 2);
                chk("hs_busy_in_done", int'(busy_v[0]), 0);
                since_done = 0;
            end else if (since_done == 0) begin
                chk("hs_idle_gap", int'(busy_v[0]), 0);
                since_done = 1;
            end else if (since_done == 1) begin
                chk("hs_restart", int'(busy_v[0]), 1);
                since_done = -1;
            end
        end
        chk("hs_done_count", n_done, 5);
        $display("txn handshake a=00f0 b=0f00 dones=%0d", n_done);
        start = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized operands, biased toward equal and near-equal pairs.
        for (int t = 0; t < 30; t++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (16'd1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            run_model(ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Sequencer that drives one shared cmp_4b nibble comparator over a wide operand pair.
- Operands are stored at start. Nibbles are compared most-significant first, with optional early exit on the first nibble that differs.
- Produces registered gt/eq/lt flags plus a done pulse.
- Sits between the ALU control path and the 4-bit comparator, so wide compares cost one comparator instead of a tree.

Parameters:
- NIBBLES, 4: number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 1..16.
- EARLY_EXIT, 1: 1 = stop at the first unequal nibble; 0 = always scan all nibbles (constant-time).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a compare; sampled only in IDLE.
- A  in  W  operand A; captured on the accepted start edge.
- B  in  W  operand B; captured on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- gt  out  1  registered result A>B.
- eq  out  1  registered result A==B.
- lt  out  1  registered result A<B.
- cycles  out  CW  number of nibbles examined in the last compare; CW = clog2(NIBBLES+1).

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; busy, done, gt, eq, lt = 0; cycles=0; operand registers and index cleared.
  - Reset during RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clk edge with start=1: latch A and B, idx=NIBBLES-1, clear gt/eq/lt and cycles, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - The combinational cmp_4b sees A_reg[4*idx+3:4*idx] and B_reg[4*idx+3:4*idx].
  - Each edge increments cycles.
  - The first nibble with gt or lt sets a sticky decided flag and the matching result.
  - EARLY_EXIT=1 and the nibble is unequal: load the result and go to DONE on that edge.
  - idx==0: if no nibble was ever unequal, set eq=1. Go to DONE.
  - Otherwise idx decrements.
  - With EARLY_EXIT=0, later nibbles never overwrite a decided result.
- DONE: done=1 for exactly one cycle; busy=0; go to IDLE unconditionally. start is ignored in DONE.
- Latency:
  - Accept edge E0, k = nibbles examined.
  - done is high during the cycle following edge E0+k.
  - Worst case is NIBBLES+1 cycles from start to done.
- gt, eq, lt, cycles:
  - Hold from done until the next accepted start, which clears them.
  - After any completed compare, exactly one of gt/eq/lt is 1.
- start while busy or in DONE: ignored, no queuing.
- start held high continuously: back-to-back compares; new data is sampled in the IDLE cycle after each done.
- A/B changes after the accept edge have no effect.
- NIBBLES=1: a single RUN cycle; done during the cycle after E0+1.

Decomposition:
- Shared include file cmp_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the nibble-width constant 4.
- One sub-module: instantiate the existing cmp_4b as the shared datapath.
- The controller contains:
  - the FSM;
  - the operand registers with the nibble mux (or left-shift registers);
  - the index down-counter;
  - the cycles counter;
  - the result registers.

Test Plan:
- Equal operands, NIBBLES=4, EARLY_EXIT=1: A=16'h1234, B=16'h1234, start pulse -> busy for 4 cycles; done in the cycle after E0+4; eq=1, gt=lt=0, cycles=4.
- MSB decides: A=16'h8000, B=16'h7FFF -> done in the cycle after E0+1; gt=1, cycles=1, busy high for 1 cycle.
- LSB decides: A=16'h1234, B=16'h1235 -> lt=1, cycles=4.
- Constant-time mode: EARLY_EXIT=0, A=16'h9000, B=16'h1FFF -> gt=1 (not overwritten by lower nibbles), cycles=4, done in the cycle after E0+4.
- Reset mid-operation: start with A=16'h1234, B=16'h1234; drop rst_n during the 2nd RUN cycle -> all outputs 0 immediately, no done. Release, then A=16'h0001, B=16'h0002 -> lt=1, cycles=4.
- Handshake: start held high for 20 cycles with A=16'h00F0, B=16'h0F00 -> repeated compares each giving lt=1, cycles=2. Each done is followed by one IDLE cycle before the next busy. Pulsing start while busy does not disturb the result or the timing.
